// File: rtl/rx_pkt_sequencer.sv
// Receive packet sequencer: tracks preamble/header/data/FCS progress, applies
// per-phase timeouts, pulses a receiver reset on failure and counts outcomes.
module rx_pkt_sequencer #(
    parameter int unsigned TIMER_WIDTH = 16,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   short_preamble_detected,
    input  logic                   long_preamble_detected,
    input  logic                   pkt_header_valid_strobe,
    input  logic                   pkt_header_valid,
    input  logic                   ht_unsupport,
    input  logic [15:0]            pkt_len,
    input  logic                   byte_out_strobe,
    input  logic                   fcs_out_strobe,
    input  logic                   fcs_ok,
    input  logic [15:0]            min_len_th,
    input  logic [TIMER_WIDTH-1:0] long_to_th,
    input  logic [TIMER_WIDTH-1:0] hdr_to_th,
    input  logic [TIMER_WIDTH-1:0] byte_gap_th,
    input  logic [TIMER_WIDTH-1:0] fcs_to_th,
    input  logic [3:0]             rst_len,
    input  logic                   cnt_clr,
    output logic                   receiver_rst,
    output logic [2:0]             state,
    output logic                   pkt_done_strobe,
    output logic [2:0]             pkt_status,
    output logic [CNT_WIDTH-1:0]   pkt_ok_count,
    output logic [CNT_WIDTH-1:0]   pkt_err_count
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StWaitLong = 3'd1,
        StWaitHdr  = 3'd2,
        StRxData   = 3'd3,
        StWaitFcs  = 3'd4,
        StRst      = 3'd5
    } state_e;

    localparam logic [2:0] StatusOk     = 3'd0;
    localparam logic [2:0] StatusFcsErr = 3'd1;
    localparam logic [2:0] StatusLongTo = 3'd2;
    localparam logic [2:0] StatusHdrBad = 3'd3;
    localparam logic [2:0] StatusHdrTo  = 3'd4;
    localparam logic [2:0] StatusByteTo = 3'd5;
    localparam logic [2:0] StatusFcsTo  = 3'd6;

    localparam logic [TIMER_WIDTH-1:0] TimerMax = {TIMER_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]   CntMax   = {CNT_WIDTH{1'b1}};

    state_e                 r_state, w_state_nxt;
    logic [TIMER_WIDTH-1:0] r_timer, w_timer_nxt;
    logic [15:0]            r_byte_cnt, w_byte_cnt_nxt;
    logic [15:0]            r_len, w_len_nxt;
    logic [2:0]             r_status, w_status_nxt;
    logic                   r_done, w_done_nxt;
    logic                   r_rcv_rst;
    logic [CNT_WIDTH-1:0]   r_ok_cnt, r_err_cnt;
    logic                   w_timer_clr;
    logic [15:0]            w_byte_inc;
    logic [TIMER_WIDTH-1:0] w_rst_len;

    // A phase times out in the cycle its dwell would reach th, so the state lasts th cycles.
    function automatic logic f_timeout(input logic [TIMER_WIDTH-1:0] th,
                                       input logic [TIMER_WIDTH-1:0] tmr);
        return (th != '0) && (tmr >= th - TIMER_WIDTH'(1));
    endfunction

    assign w_rst_len  = (rst_len == 4'd0) ? TIMER_WIDTH'(1) : TIMER_WIDTH'(rst_len);
    assign w_byte_inc = r_byte_cnt + 16'd1;

    // Next-state and registered-output decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_status_nxt   = r_status;
        w_done_nxt     = 1'b0;
        w_len_nxt      = r_len;
        w_byte_cnt_nxt = r_byte_cnt;
        w_timer_clr    = 1'b0;
        case (r_state)
            StIdle: begin
                if (short_preamble_detected) w_state_nxt = StWaitLong;
            end
            StWaitLong: begin
                if (long_preamble_detected) begin
                    w_state_nxt = StWaitHdr;
                end else if (f_timeout(long_to_th, r_timer)) begin
                    w_state_nxt  = StRst;
                    w_done_nxt   = 1'b1;
                    w_status_nxt = StatusLongTo;
                end
            end
            StWaitHdr: begin
                if (pkt_header_valid_strobe) begin
                    if (pkt_header_valid && !ht_unsupport && (pkt_len >= min_len_th)) begin
                        w_len_nxt      = pkt_len;
                        w_byte_cnt_nxt = 16'd0;
                        w_state_nxt    = StRxData;
                    end else begin
                        w_state_nxt  = StRst;
                        w_done_nxt   = 1'b1;
                        w_status_nxt = StatusHdrBad;
                    end
                end else if (f_timeout(hdr_to_th, r_timer)) begin
                    w_state_nxt  = StRst;
                    w_done_nxt   = 1'b1;
                    w_status_nxt = StatusHdrTo;
                end
            end
            StRxData: begin
                // FCS outranks a coincident byte strobe.
                if (fcs_out_strobe) begin
                    w_state_nxt  = StIdle;
                    w_done_nxt   = 1'b1;
                    w_status_nxt = fcs_ok ? StatusOk : StatusFcsErr;
                end else if (byte_out_strobe) begin
                    w_byte_cnt_nxt = w_byte_inc;
                    w_timer_clr    = 1'b1;
                    if (w_byte_inc == r_len) w_state_nxt = StWaitFcs;
                end else if (f_timeout(byte_gap_th, r_timer)) begin
                    w_state_nxt  = StRst;
                    w_done_nxt   = 1'b1;
                    w_status_nxt = StatusByteTo;
                end
            end
            StWaitFcs: begin
                if (fcs_out_strobe) begin
                    w_state_nxt  = StIdle;
                    w_done_nxt   = 1'b1;
                    w_status_nxt = fcs_ok ? StatusOk : StatusFcsErr;
                end else if (f_timeout(fcs_to_th, r_timer)) begin
                    w_state_nxt  = StRst;
                    w_done_nxt   = 1'b1;
                    w_status_nxt = StatusFcsTo;
                end
            end
            StRst: begin
                if (r_timer >= w_rst_len - TIMER_WIDTH'(1)) w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
        // Disable wins over everything: silent return to idle, status held.
        if (!enable) begin
            w_state_nxt    = StIdle;
            w_done_nxt     = 1'b0;
            w_status_nxt   = r_status;
            w_len_nxt      = r_len;
            w_byte_cnt_nxt = r_byte_cnt;
        end
    end

    // Timer restarts on state change or accepted byte, otherwise saturating count.
    always_comb begin
        if ((w_state_nxt != r_state) || (w_timer_clr && enable)) begin
            w_timer_nxt = '0;
        end else if (r_timer != TimerMax) begin
            w_timer_nxt = r_timer + TIMER_WIDTH'(1);
        end else begin
            w_timer_nxt = r_timer;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= StIdle;
            r_timer    <= '0;
            r_byte_cnt <= 16'd0;
            r_len      <= 16'd0;
            r_status   <= StatusOk;
            r_done     <= 1'b0;
            r_rcv_rst  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_len      <= w_len_nxt;
            r_status   <= w_status_nxt;
            r_done     <= w_done_nxt;
            r_rcv_rst  <= (w_state_nxt == StRst);
        end
    end

    // Outcome counters follow the visible done pulse so a coincident clear wins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ok_cnt  <= '0;
            r_err_cnt <= '0;
        end else if (cnt_clr) begin
            r_ok_cnt  <= '0;
            r_err_cnt <= '0;
        end else if (r_done) begin
            if (r_status == StatusOk) begin
                if (r_ok_cnt != CntMax) r_ok_cnt <= r_ok_cnt + CNT_WIDTH'(1);
            end else begin
                if (r_err_cnt != CntMax) r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign receiver_rst    = r_rcv_rst;
    assign state           = r_state;
    assign pkt_done_strobe = r_done;
    assign pkt_status      = r_status;
    assign pkt_ok_count    = r_ok_cnt;
    assign pkt_err_count   = r_err_cnt;

endmodule

// File: tb/tb_rx_pkt_sequencer.sv
// Scoreboard bench for rx_pkt_sequencer: stimulus pushes expected statuses,
// a negedge monitor pops them on every pkt_done_strobe.
module tb_rx_pkt_sequencer;

    localparam int unsigned TW = 16;
    localparam int unsigned CW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          short_preamble_detected = 1'b0;
    logic          long_preamble_detected = 1'b0;
    logic          pkt_header_valid_strobe = 1'b0;
    logic          pkt_header_valid = 1'b0;
    logic          ht_unsupport = 1'b0;
    logic [15:0]   pkt_len = 16'd0;
    logic          byte_out_strobe = 1'b0;
    logic          fcs_out_strobe = 1'b0;
    logic          fcs_ok = 1'b0;
    logic [15:0]   min_len_th = 16'd1;
    logic [TW-1:0] long_to_th = 16'd20;
    logic [TW-1:0] hdr_to_th = 16'd20;
    logic [TW-1:0] byte_gap_th = 16'd20;
    logic [TW-1:0] fcs_to_th = 16'd20;
    logic [3:0]    rst_len = 4'd3;
    logic          cnt_clr = 1'b0;
    logic          receiver_rst;
    logic [2:0]    state;
    logic          pkt_done_strobe;
    logic [2:0]    pkt_status;
    logic [CW-1:0] pkt_ok_count;
    logic [CW-1:0] pkt_err_count;

    int tests = 0;
    int fails = 0;
    int exp_q[$];

    rx_pkt_sequencer #(.TIMER_WIDTH(TW), .CNT_WIDTH(CW)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .short_preamble_detected(short_preamble_detected),
        .long_preamble_detected(long_preamble_detected),
        .pkt_header_valid_strobe(pkt_header_valid_strobe),
        .pkt_header_valid(pkt_header_valid), .ht_unsupport(ht_unsupport),
        .pkt_len(pkt_len), .byte_out_strobe(byte_out_strobe),
        .fcs_out_strobe(fcs_out_strobe), .fcs_ok(fcs_ok), .min_len_th(min_len_th),
        .long_to_th(long_to_th), .hdr_to_th(hdr_to_th), .byte_gap_th(byte_gap_th),
        .fcs_to_th(fcs_to_th), .rst_len(rst_len), .cnt_clr(cnt_clr),
        .receiver_rst(receiver_rst), .state(state), .pkt_done_strobe(pkt_done_strobe),
        .pkt_status(pkt_status), .pkt_ok_count(pkt_ok_count), .pkt_err_count(pkt_err_count)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected status.
    always @(negedge clock) begin
        if (!reset && pkt_done_strobe) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got status %0d expected no pulse", pkt_status);
            end else begin
                check("pkt_status", int'(pkt_status), exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(negedge clock);
    endtask

    task automatic pulse_short();
        short_preamble_detected = 1'b1; step(); short_preamble_detected = 1'b0;
    endtask

    task automatic pulse_long();
        long_preamble_detected = 1'b1; step(); long_preamble_detected = 1'b0;
    endtask

    task automatic pulse_hdr(input logic vld, input logic ht, input logic [15:0] len);
        pkt_header_valid = vld; ht_unsupport = ht; pkt_len = len;
        pkt_header_valid_strobe = 1'b1; step(); pkt_header_valid_strobe = 1'b0;
    endtask

    task automatic pulse_byte();
        byte_out_strobe = 1'b1; step(); byte_out_strobe = 1'b0;
    endtask

    task automatic pulse_fcs(input logic ok);
        fcs_ok = ok; fcs_out_strobe = 1'b1; step(); fcs_out_strobe = 1'b0;
    endtask

    task automatic enter_rx(input logic [15:0] len);
        pulse_short(); pulse_long(); pulse_hdr(1'b1, 1'b0, len);
    endtask

    // Cycles until the given state appears, bounded.
    task automatic cycles_to_state(input logic [2:0] st, output int n);
        n = 0;
        while (state != st && n < 400) begin step(); n++; end
    endtask

    // Length of the receiver_rst pulse, counted from its first visible cycle.
    task automatic rst_pulse_len(output int n);
        n = 0;
        while (receiver_rst && n < 20) begin step(); n++; end
    endtask

    int n;

    initial begin
        step();
        check("rst_state", int'(state), 0);
        check("rst_receiver_rst", int'(receiver_rst), 0);
        check("rst_done", int'(pkt_done_strobe), 0);
        check("rst_status", int'(pkt_status), 0);
        check("rst_ok_cnt", int'(pkt_ok_count), 0);
        check("rst_err_cnt", int'(pkt_err_count), 0);
        reset = 1'b0; enable = 1'b1;
        step();

        // Inputs for other states are ignored in IDLE.
        pulse_long();
        pulse_hdr(1'b1, 1'b0, 16'd4);
        check("idle_ignores", int'(state), 0);

        // Good packet.
        pulse_short();               check("good_s1", int'(state), 1);
        pulse_long();                check("good_s2", int'(state), 2);
        pulse_hdr(1'b1, 1'b0, 16'd4); check("good_s3", int'(state), 3);
        for (int i = 0; i < 4; i++) begin
            pulse_byte();
            check("good_bytes", int'(state), (i == 3) ? 4 : 3);
        end
        exp_q.push_back(0);
        pulse_fcs(1'b1);             check("good_s0", int'(state), 0);
        step(); step();
        check("good_ok_cnt", int'(pkt_ok_count), 1);

        // Bad header (HT unsupported), 3-cycle receiver reset.
        pulse_short(); pulse_long();
        exp_q.push_back(3);
        pulse_hdr(1'b1, 1'b1, 16'd4);
        check("badhdr_rst_state", int'(state), 5);
        rst_pulse_len(n);
        check("badhdr_rst_len", n, 3);
        check("badhdr_idle", int'(state), 0);
        step();
        check("badhdr_err_cnt", int'(pkt_err_count), 1);

        // Byte gap timeout after 5 of 8 bytes.
        byte_gap_th = 16'd10;
        enter_rx(16'd8);
        for (int i = 0; i < 5; i++) pulse_byte();
        check("gap_in_rx", int'(state), 3);
        exp_q.push_back(5);
        cycles_to_state(3'd5, n);
        check("gap_cycles", n, 10);
        byte_gap_th = 16'd20;
        cycles_to_state(3'd0, n);
        check("gap_back_idle", n, 3);

        // Coincident last byte and FCS error: FCS wins.
        enter_rx(16'd4);
        for (int i = 0; i < 3; i++) pulse_byte();
        exp_q.push_back(1);
        byte_out_strobe = 1'b1;
        pulse_fcs(1'b0);
        byte_out_strobe = 1'b0;
        check("simul_idle", int'(state), 0);

        // Header timeout.
        hdr_to_th = 16'd5;
        pulse_short(); pulse_long();
        exp_q.push_back(4);
        cycles_to_state(3'd5, n);
        check("hdrto_cycles", n, 5);
        hdr_to_th = 16'd20;
        cycles_to_state(3'd0, n);

        // FCS timeout.
        fcs_to_th = 16'd4;
        enter_rx(16'd1);
        pulse_byte();
        check("fcsto_wait", int'(state), 4);
        exp_q.push_back(6);
        cycles_to_state(3'd5, n);
        check("fcsto_cycles", n, 4);
        fcs_to_th = 16'd20;
        cycles_to_state(3'd0, n);

        // long_to_th=0 never times out; then a 1-cycle reset with rst_len=0.
        long_to_th = 16'd0;
        rst_len = 4'd0;
        pulse_short();
        repeat (300) step();
        check("longto0_persist", int'(state), 1);
        exp_q.push_back(2);
        long_to_th = 16'd5;
        step();
        check("longto_rst", int'(state), 5);
        check("longto_rcv_rst", int'(receiver_rst), 1);
        rst_pulse_len(n);
        check("rstlen0_pulse", n, 1);
        check("rstlen0_idle", int'(state), 0);
        long_to_th = 16'd20;
        rst_len = 4'd3;

        // Disable mid-packet: silent return to IDLE.
        enter_rx(16'd8);
        pulse_byte();
        enable = 1'b0;
        step();
        check("dis_idle", int'(state), 0);
        check("dis_rcv_rst", int'(receiver_rst), 0);
        enable = 1'b1;
        step(); step();
        check("err_total", int'(pkt_err_count), 6);
        check("ok_total", int'(pkt_ok_count), 1);

        // Asynchronous reset mid-packet.
        pulse_short(); pulse_long();
        reset = 1'b1;
        #1;
        check("midrst_state", int'(state), 0);
        check("midrst_err_cnt", int'(pkt_err_count), 0);
        step();
        reset = 1'b0;
        step();

        // Error counter saturation, then clear coincident with a done pulse.
        long_to_th = 16'd1;
        rst_len = 4'd1;
        for (int i = 0; i < 260; i++) begin
            exp_q.push_back(2);
            pulse_short(); step(); step();
        end
        check("err_saturate", int'(pkt_err_count), 255);
        exp_q.push_back(2);
        pulse_short(); step();
        check("clr_done_seen", int'(pkt_done_strobe), 1);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("clr_wins", int'(pkt_err_count), 0);
        step();
        check("clr_held", int'(pkt_err_count), 0);

        step(); step();
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rx_pkt_sequencer.md
RX_PKT_SEQUENCER -- requirements
Module: rx_pkt_sequencer

Interface
REQ-001 SHALL have parameter TIMER_WIDTH, default 16, giving the width of the timeout timer and every threshold.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, giving the width of the packet counters.
REQ-003 SHALL have the following ports, clock and reset first:
- clock  in  1  sole clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  sequencer enable; low forces IDLE.
- short_preamble_detected  in  1  pulse, short preamble found.
- long_preamble_detected  in  1  pulse, long preamble found.
- pkt_header_valid_strobe  in  1  pulse, header decode finished.
- pkt_header_valid  in  1  header good; qualified by the strobe.
- ht_unsupport  in  1  HT mode unsupported; qualified by the strobe.
- pkt_len  in  16  header length in bytes; qualified by the strobe.
- byte_out_strobe  in  1  one decoded byte delivered.
- fcs_out_strobe  in  1  FCS result available.
- fcs_ok  in  1  FCS pass; qualified by fcs_out_strobe.
- min_len_th  in  16  minimum acceptable pkt_len.
- long_to_th, hdr_to_th, byte_gap_th, fcs_to_th  in  TIMER_WIDTH each  timeout thresholds; 0 disables that timeout.
- rst_len  in  4  receiver reset pulse length in cycles; 0 is treated as 1.
- cnt_clr  in  1  synchronous clear of the packet counters.
- receiver_rst  out  1  registered reset request to the receiver core.
- state  out  3  current state encoding.
- pkt_done_strobe  out  1  one-cycle pulse when a packet attempt ends.
- pkt_status  out  3  result code, valid with pkt_done_strobe and held until the next pulse.
- pkt_ok_count  out  CNT_WIDTH  saturating count of FCS-good packets.
- pkt_err_count  out  CNT_WIDTH  saturating count of all other terminations.

Function
REQ-004 SHALL implement the states IDLE=0, WAIT_LONG=1, WAIT_HDR=2, RX_DATA=3, WAIT_FCS=4, RST=5; codes 6-7 SHALL recover to IDLE on the next cycle.
REQ-005 SHALL register all outputs, so each transition and its outputs appear on the cycle after the triggering input.
REQ-006 SHALL keep a TIMER_WIDTH timer that saturates at all-ones, clears on every state change, and increments in every other cycle.
REQ-007 In IDLE, short_preamble_detected SHALL move the block to WAIT_LONG.
REQ-008 In WAIT_LONG, long_preamble_detected SHALL move the block to WAIT_HDR; otherwise, when the timer reaches long_to_th (nonzero), it SHALL move to RST with status 2 (LONG_TO).
REQ-009 In WAIT_HDR, pkt_header_valid_strobe SHALL be handled as follows:
- pkt_header_valid=1 and ht_unsupport=0 and pkt_len>=min_len_th: latch pkt_len, clear the byte count, go to RX_DATA.
- otherwise: go to RST with status 3 (HDR_BAD).
- timer reaching hdr_to_th without the strobe: go to RST with status 4 (HDR_TO).
REQ-010 In RX_DATA, each byte_out_strobe SHALL increment a 16-bit byte count and clear the timer; when the incremented count equals the latched length, the block SHALL go to WAIT_FCS.
REQ-011 In RX_DATA, the timer reaching byte_gap_th SHALL move the block to RST with status 5 (BYTE_TO).
REQ-012 In RX_DATA or WAIT_FCS, fcs_out_strobe SHALL move the block to IDLE, pulse pkt_done_strobe, and set pkt_status to 0 (OK) if fcs_ok=1, else 1 (FCS_ERR).
REQ-013 If fcs_out_strobe and byte_out_strobe occur in the same cycle, the FCS event SHALL take precedence.
REQ-014 In WAIT_FCS, the timer reaching fcs_to_th SHALL move the block to RST with status 6 (FCS_TO).
REQ-015 Entering RST SHALL pulse pkt_done_strobe with the stated status and assert receiver_rst for exactly max(rst_len,1) cycles, after which the block SHALL return to IDLE with receiver_rst low.
REQ-016 Every start-of-packet and header input SHALL be ignored outside the state that consumes it.
REQ-017 On each pkt_done_strobe, pkt_ok_count SHALL increment if status=0 and pkt_err_count SHALL increment otherwise; both counters SHALL saturate at all-ones.
REQ-018 cnt_clr SHALL zero both counters and SHALL win over a simultaneous increment.
REQ-019 enable=0 SHALL force IDLE on the next cycle with receiver_rst low and no pkt_done_strobe; an in-progress RST pulse SHALL be truncated, and the counters SHALL be held.

Reset
REQ-020 reset=1 SHALL asynchronously set state=IDLE, receiver_rst=0, pkt_done_strobe=0, pkt_status=0, both counters=0, timer=0, byte count=0, and latched length=0.
REQ-021 Reset asserted mid-packet SHALL abandon the packet without a pkt_done_strobe.

Verification
REQ-022 Good packet: short, long, header (valid, len=4, min_len_th=1), 4 byte strobes, fcs_ok=1 -> states 1,2,3,4,0; pkt_status=0; pkt_ok_count=1.
REQ-023 Bad header: header strobe with ht_unsupport=1, rst_len=3 -> pkt_status=3; receiver_rst high exactly 3 cycles; then IDLE; pkt_err_count=1.
REQ-024 Byte gap: byte_gap_th=10, len=8, bytes stop after 5 -> RST entered 10 cycles after the last byte; pkt_status=5.
REQ-025 Simultaneous: in RX_DATA, byte_out_strobe and fcs_out_strobe together with fcs_ok=0 -> IDLE; pkt_status=1; byte count ignored.
REQ-026 Counters: force 0xFFFF errors -> pkt_err_count holds 0xFFFF; cnt_clr coincident with pkt_done_strobe -> pkt_err_count=0.
REQ-027 Thresholds: long_to_th=0 -> WAIT_LONG persists indefinitely; rst_len=0 -> receiver_rst pulse of 1 cycle.
